// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: ID-stage forwarding, load-use and memory-wait
// stalls, stage enables/flushes, and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rs1_ID,
  input  logic [RA_W-1:0]  rs2_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic             Branch_ID,
  input  logic             store_ID,
  input  logic [RA_W-1:0]  rd_EXE,
  input  logic [RA_W-1:0]  rd_MEM,
  input  logic             rd_w_EXE,
  input  logic             rd_w_MEM,
  input  logic             load_EXE,
  input  logic             load_MEM,
  input  logic             store_EXE,
  input  logic [RA_W-1:0]  rs2_EXE,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_DE_EN,
  output logic             reg_EM_EN,
  output logic             reg_MW_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic             reg_EM_flush,
  output logic             reg_MW_flush,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  input  logic [1:0]       perf_sel,
  output logic [CNT_W-1:0] perf_data,
  output logic             mem_err
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WMAX = WC_W'(WAIT_MAX);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state, state_nx;
  logic [WC_W-1:0] wcnt, wcnt_nx;
  logic            set_err;
  logic            mw, lu, lu_eff;
  logic            exe_live, mem_live;
  logic [CNT_W-1:0] cyc, lu_cnt, fl_cnt, mw_cnt;

  assign exe_live = rd_w_EXE && (rd_EXE != '0);
  assign mem_live = rd_w_MEM && (rd_MEM != '0);

  always_comb begin
    forward_ctrl_A = 2'd0;
    if (rs1use_ID && exe_live && !load_EXE && rd_EXE == rs1_ID)
      forward_ctrl_A = 2'd1;
    else if (rs1use_ID && mem_live && rd_MEM == rs1_ID)
      forward_ctrl_A = load_MEM ? 2'd3 : 2'd2;
  end

  always_comb begin
    forward_ctrl_B = 2'd0;
    if (rs2use_ID && exe_live && !load_EXE && rd_EXE == rs2_ID)
      forward_ctrl_B = 2'd1;
    else if (rs2use_ID && mem_live && rd_MEM == rs2_ID)
      forward_ctrl_B = load_MEM ? 2'd3 : 2'd2;
  end

  assign forward_ctrl_ls = store_EXE && load_MEM && mem_live && (rd_MEM == rs2_EXE);

  // A store's data operand can wait for the load in MEM via forward_ctrl_ls.
  assign lu = load_EXE && exe_live &&
              ((rs1use_ID && rd_EXE == rs1_ID) ||
               (rs2use_ID && rd_EXE == rs2_ID && !store_ID));

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    set_err  = 1'b0;
    mw       = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req_MEM && !dmem_ready) begin
          mw       = 1'b1;
          state_nx = MEM_WAIT;
          wcnt_nx  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || wcnt == WMAX) begin
          set_err  = !dmem_ready;
          state_nx = RUN;
          wcnt_nx  = '0;
        end else begin
          mw      = 1'b1;
          wcnt_nx = wcnt + 1'b1;
        end
      end
      default: begin
        state_nx = RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      if (set_err) mem_err <= 1'b1;
    end
  end

  assign lu_eff = lu && !mw;

  always_comb begin
    PC_EN_IF     = !mw && !lu;
    reg_FD_EN    = !mw && !lu;
    reg_DE_EN    = !mw;
    reg_EM_EN    = !mw;
    reg_MW_EN    = 1'b1;
    reg_FD_flush = !mw && !lu && Branch_ID;
    reg_DE_flush = lu_eff;
    reg_EM_flush = 1'b0;
    reg_MW_flush = mw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= '0;
      lu_cnt <= '0;
      fl_cnt <= '0;
      mw_cnt <= '0;
    end else begin
      if (cyc != '1) cyc <= cyc + 1'b1;
      if (lu_eff && lu_cnt != '1) lu_cnt <= lu_cnt + 1'b1;
      if (reg_FD_flush && fl_cnt != '1) fl_cnt <= fl_cnt + 1'b1;
      if (mw && mw_cnt != '1) mw_cnt <= mw_cnt + 1'b1;
    end
  end

  always_comb begin
    case (perf_sel)
      2'd0:    perf_data = cyc;
      2'd1:    perf_data = lu_cnt;
      2'd2:    perf_data = fl_cnt;
      default: perf_data = mw_cnt;
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int RA_W = 5;
  localparam int CNT_W = 8;
  localparam int WAIT_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic rs1use_ID, rs2use_ID, Branch_ID, store_ID, rd_w_EXE, rd_w_MEM;
  logic load_EXE, load_MEM, store_EXE, dmem_req_MEM, dmem_ready;
  logic PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
  logic reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic [1:0] forward_ctrl_A, forward_ctrl_B, perf_sel;
  logic forward_ctrl_ls, mem_err;
  logic [CNT_W-1:0] perf_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  bit          m_waiting;
  int unsigned m_waited;
  bit          m_err;
  int unsigned m_cnt [4];
  localparam int unsigned CAP = (1 << CNT_W) - 1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .Branch_ID(Branch_ID), .store_ID(store_ID),
    .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rd_w_EXE(rd_w_EXE), .rd_w_MEM(rd_w_MEM),
    .load_EXE(load_EXE), .load_MEM(load_MEM), .store_EXE(store_EXE), .rs2_EXE(rs2_EXE),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_DE_EN(reg_DE_EN),
    .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls),
    .perf_sel(perf_sel), .perf_data(perf_data), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_waited = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs, input logic used);
    if (!used || rs == 0) return 2'd0;
    if (rd_w_EXE && !load_EXE && rd_EXE == rs) return 2'd1;
    if (rd_w_MEM && rd_MEM == rs) return load_MEM ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_lu();
    bit hit1, hit2;
    if (!(load_EXE && rd_w_EXE && rd_EXE != 0)) return 0;
    hit1 = rs1use_ID && rd_EXE == rs1_ID;
    hit2 = rs2use_ID && rd_EXE == rs2_ID;
    return hit1 || (hit2 && !store_ID);
  endfunction

  function automatic bit m_mw();
    if (!m_waiting) return dmem_req_MEM && !dmem_ready;
    return !dmem_ready && m_waited < WAIT_MAX;
  endfunction

  task automatic check_all();
    bit mw, lu, run, fl;
    mw = m_mw(); lu = m_lu(); run = !mw;
    fl = run && !lu && Branch_ID;
    chk("pc_en",    PC_EN_IF,     run && !lu);
    chk("fd_en",    reg_FD_EN,    run && !lu);
    chk("de_en",    reg_DE_EN,    run);
    chk("em_en",    reg_EM_EN,    run);
    chk("mw_en",    reg_MW_EN,    1);
    chk("fd_flush", reg_FD_flush, fl);
    chk("de_flush", reg_DE_flush, run && lu);
    chk("em_flush", reg_EM_flush, 0);
    chk("mw_flush", reg_MW_flush, mw);
    chk("fwd_a",    forward_ctrl_A, m_fwd(rs1_ID, rs1use_ID));
    chk("fwd_b",    forward_ctrl_B, m_fwd(rs2_ID, rs2use_ID));
    chk("fwd_ls",   forward_ctrl_ls,
        store_EXE && load_MEM && rd_w_MEM && rd_MEM != 0 && rd_MEM == rs2_EXE);
    chk("perf",     perf_data, m_cnt[perf_sel]);
    chk("mem_err",  mem_err, m_err);
  endtask

  task automatic model_clock();
    bit mw, lu;
    mw = m_mw(); lu = m_lu();
    if (m_cnt[0] < CAP) m_cnt[0]++;
    if (lu && !mw && m_cnt[1] < CAP) m_cnt[1]++;
    if (!mw && !lu && Branch_ID && m_cnt[2] < CAP) m_cnt[2]++;
    if (mw && m_cnt[3] < CAP) m_cnt[3]++;
    if (!m_waiting) begin
      if (dmem_req_MEM && !dmem_ready) begin m_waiting = 1; m_waited = 1; end
    end else if (dmem_ready || m_waited == WAIT_MAX) begin
      if (!dmem_ready) m_err = 1;
      m_waiting = 0;
    end else m_waited++;
  endtask

  // Check combinational outputs mid-cycle, then advance the model over the edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (!rst) model_clock();
    #1;
  endtask

  task automatic idle();
    rs1_ID = 0; rs2_ID = 0; rd_EXE = 0; rd_MEM = 0; rs2_EXE = 0;
    rs1use_ID = 0; rs2use_ID = 0; Branch_ID = 0; store_ID = 0;
    rd_w_EXE = 0; rd_w_MEM = 0; load_EXE = 0; load_MEM = 0; store_EXE = 0;
    dmem_req_MEM = 0; dmem_ready = 0;
  endtask

  task automatic load_use(input bit st);
    idle(); perf_sel = 1;
    load_EXE = 1; rd_EXE = 7; rd_w_EXE = 1; rs2_ID = 7; rs2use_ID = 1; store_ID = st;
  endtask

  initial begin
    idle(); perf_sel = 0; rst = 1; model_reset();
    // Forwarding stays live while reset is held
    rs1_ID = 5; rs1use_ID = 1; rd_EXE = 5; rd_w_EXE = 1;
    #3; chk("rst_fwd_a", forward_ctrl_A, 2'd1); chk("rst_perf", perf_data, 0);
    step();
    rst = 0;

    step(); chk("fwd_a_exe", forward_ctrl_A, 2'd1);
    rd_w_EXE = 0; rd_MEM = 5; rd_w_MEM = 1; load_MEM = 1;
    #1; chk("fwd_a_mem_load", forward_ctrl_A, 2'd3); step();
    rd_w_EXE = 1; load_MEM = 0;
    #1; chk("fwd_a_prio", forward_ctrl_A, 2'd1); step();

    load_use(0);
    #1; chk("lu_pc_en", PC_EN_IF, 0); chk("lu_de_flush", reg_DE_flush, 1); step();
    idle(); rs2_ID = 7; rs2use_ID = 1; rd_MEM = 7; rd_w_MEM = 1; load_MEM = 1;
    #1; chk("lu_fwd_b", forward_ctrl_B, 2'd3); chk("lu_cnt", perf_data, 1);
    chk("lu_no_stall", PC_EN_IF, 1); step();

    load_use(1);
    #1; chk("st_no_stall", PC_EN_IF, 1); step();
    idle(); store_EXE = 1; rs2_EXE = 7; rd_MEM = 7; rd_w_MEM = 1; load_MEM = 1;
    #1; chk("fwd_ls", forward_ctrl_ls, 1); step();

    load_use(0); Branch_ID = 1; perf_sel = 2;
    #1; chk("br_lu_flush", reg_FD_flush, 0); chk("br_lu_stall", PC_EN_IF, 0); step();
    idle(); Branch_ID = 1;
    #1; chk("br_flush", reg_FD_flush, 1); chk("fl_before", perf_data, 0); step();
    idle(); #1; chk("fl_after", perf_data, 1); step();

    // Three-cycle memory wait
    perf_sel = 3; dmem_req_MEM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("mw_pc_en", PC_EN_IF, 0); chk("mw_flush", reg_MW_flush, 1); step();
    end
    dmem_ready = 1; #1; chk("mw_done", PC_EN_IF, 1); step();
    idle(); #1; chk("mw_cnt", perf_data, 3); chk("mw_err0", mem_err, 0); step();

    // Timeout
    dmem_req_MEM = 1; dmem_ready = 0;
    for (int i = 0; i < WAIT_MAX; i++) step();
    #1; chk("to_resume", PC_EN_IF, 1); step();
    idle(); #1; chk("to_err", mem_err, 1); step();
    step(); chk("to_sticky", mem_err, 1);

    // Reset in the middle of a wait
    dmem_req_MEM = 1; dmem_ready = 0; perf_sel = 0;
    step(); step();
    idle(); rst = 1; model_reset();
    #1; chk("rst_perf0", perf_data, 0); chk("rst_err0", mem_err, 0);
    chk("rst_run", PC_EN_IF, 1);
    rst = 0;
    step();

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) model_reset();
      rs1_ID = RA_W'($urandom_range(0, 7)); rs2_ID = RA_W'($urandom_range(0, 7));
      rd_EXE = RA_W'($urandom_range(0, 7)); rd_MEM = RA_W'($urandom_range(0, 7));
      rs2_EXE = RA_W'($urandom_range(0, 7));
      rs1use_ID = 1'($urandom); rs2use_ID = 1'($urandom);
      Branch_ID = ($urandom_range(0, 3) == 0); store_ID = 1'($urandom);
      rd_w_EXE = 1'($urandom); rd_w_MEM = 1'($urandom);
      load_EXE = 1'($urandom); load_MEM = 1'($urandom); store_EXE = 1'($urandom);
      dmem_req_MEM = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 3) == 0);
      perf_sel = 2'($urandom);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameters: RA_W, default 5, register-address width; CNT_W, default 32, performance-counter width; WAIT_MAX, default 16, maximum memory-wait cycles before timeout.
REQ-002 SHALL have these ports, clock and reset first:
- clk in 1: clock; the only clock in the block.
- rst in 1: reset; asynchronous, active-high.
- rs1_ID, rs2_ID in RA_W: source registers of the instruction in ID.
- rs1use_ID, rs2use_ID in 1: the corresponding source is read.
- Branch_ID in 1: taken branch or jump resolved in ID.
- store_ID in 1: the ID instruction is a store.
- rd_EXE, rd_MEM in RA_W: destination registers.
- rd_w_EXE, rd_w_MEM in 1: destination is written.
- load_EXE, load_MEM in 1: the instruction in that stage is a load.
- store_EXE in 1: the EXE instruction is a store.
- rs2_EXE in RA_W: store-data source register in EXE.
- dmem_req_MEM in 1: MEM stage accesses data memory.
- dmem_ready in 1: data memory completes the access this cycle.
- PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN out 1: stage enables.
- reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush out 1: bubble insert.
- forward_ctrl_A, forward_ctrl_B out 2: ID operand select (0 regfile, 1 ALUout_EXE, 2 ALUout_MEM, 3 Datain_MEM).
- forward_ctrl_ls out 1: EXE store data taken from Datain_MEM.
- perf_sel in 2: counter select.
- perf_data out CNT_W: selected counter.
- mem_err out 1: sticky memory-timeout flag.

Function
REQ-003 SHALL compute forwarding combinationally; register 0 is never a forwarding match.
REQ-004 forward_ctrl_A SHALL equal 1 when rs1use_ID && rd_w_EXE && !load_EXE && rd_EXE==rs1_ID.
REQ-005 Otherwise, forward_ctrl_A SHALL equal 2 on a MEM match with !load_MEM, 3 on a MEM match with load_MEM, and 0 otherwise. EXE has priority over MEM.
REQ-006 forward_ctrl_B SHALL follow REQ-004/005 using rs2_ID and rs2use_ID.
REQ-007 forward_ctrl_ls SHALL be 1 iff store_EXE && load_MEM && rd_w_MEM && rd_MEM!=0 && rd_MEM==rs2_EXE.
REQ-008 Load-use hazard (lu) SHALL be asserted when load_EXE && rd_w_EXE && rd_EXE!=0 and the EXE destination matches a used source in ID.
REQ-009 The exception to REQ-008: a match on rs2 only, with store_ID=1, SHALL NOT raise lu, because it is resolved by forward_ctrl_ls.
REQ-010 FSM states SHALL be RUN and MEM_WAIT, with a wait counter wcnt of width clog2(WAIT_MAX+1).
REQ-011 RUN->MEM_WAIT SHALL occur when dmem_req_MEM && !dmem_ready; wcnt is loaded with 1.
REQ-012 MEM_WAIT->RUN SHALL occur when dmem_ready=1 or wcnt==WAIT_MAX. On timeout, mem_err is set (sticky).
REQ-013 Otherwise, MEM_WAIT SHALL remain and wcnt SHALL increment.
REQ-014 Stall condition mw SHALL be (state==RUN && dmem_req_MEM && !dmem_ready) || (state==MEM_WAIT && !dmem_ready && wcnt!=WAIT_MAX).
REQ-015 Stage-control priority SHALL be mw > lu > Branch_ID. Outputs not listed for a case are 0 (flushes) or 1 (enables).
- When mw is active: PC_EN_IF, reg_FD_EN, reg_DE_EN and reg_EM_EN are 0; reg_MW_flush is 1.
- Else when lu is active: PC_EN_IF and reg_FD_EN are 0; reg_DE_flush is 1. Branch_ID is ignored that cycle.
- Else when Branch_ID is active: reg_FD_flush is 1.
REQ-016 reg_EM_flush SHALL be constantly 0 and reg_MW_EN constantly 1.
REQ-017 Counters SHALL be CNT_W wide, saturate at all-ones, and never wrap:
- cyc increments every cycle;
- lu_cnt increments on lu cycles counted per REQ-015;
- fl_cnt increments on cycles where reg_FD_flush=1;
- mw_cnt increments on mw cycles.
REQ-018 perf_data SHALL select by perf_sel: 0 cyc, 1 lu_cnt, 2 fl_cnt, 3 mw_cnt. The selection is combinational.

Reset
REQ-019 On rst=1, asynchronously: state=RUN, wcnt=0, all counters=0, mem_err=0.
REQ-020 Combinational outputs SHALL continue to follow their inputs during reset.
REQ-021 Reset asserted during MEM_WAIT SHALL abandon the wait immediately; there is no pending-state carry-over.

Verification
REQ-022 Bench stimuli SHALL include:
- rd_EXE=5 ALU op, rs1_ID=5 used -> forward_ctrl_A=1.
- Same rd in MEM as a load -> forward_ctrl_A=3.
- rd_EXE=rd_MEM=5, both non-load -> forward_ctrl_A=1.
- load_EXE rd=7, rs2_ID=7 used, store_ID=0 -> one cycle with PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1. Next cycle (load in MEM) -> forward_ctrl_B=3, no stall; lu_cnt=1.
- Same as above with store_ID=1 -> no stall. Next cycle, store_EXE with rs2_EXE=7 -> forward_ctrl_ls=1.
- Branch_ID=1 together with lu -> reg_FD_flush=0, stall only. Branch_ID=1 without lu -> reg_FD_flush=1, fl_cnt+1.
- dmem_req_MEM=1, dmem_ready low for 3 cycles then high -> enables low for 3 cycles, reg_MW_flush high for 3 cycles, mw_cnt=3, state back to RUN, mem_err=0.
- dmem_ready held low with WAIT_MAX=4 -> mem_err=1 after the 4th wait cycle; pipeline resumes; mem_err stays 1 until rst.
- Pulse rst in MEM_WAIT -> state RUN, counters 0 within the same cycle, before the next clk edge.
